wf_exec_state: RTL and testbench

WF_EXEC_STATE -- requirements
Module: wf_exec_state

---
 rtl/wf_exec_state_pkg.sv | 18 +
 rtl/wf_state_bank.sv | 63 ++++++
 rtl/wf_exec_state.sv | 119 +++++++++++
 tb/tb_wf_exec_state.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wf_exec_state_pkg.sv
// Shared constants for the wavefront execution-state slice: entry count,
// wavefront id width and the width of every stored field.
package wf_exec_state_pkg;

    localparam int NUM_WF_DEFAULT = 40;
    localparam int WFID_W         = 6;
    localparam int EXEC_W         = 64;
    localparam int VCC_W          = 64;
    localparam int M0_W           = 32;
    localparam int SCC_W          = 1;

    // True when a wavefront id addresses an entry that actually exists.
    function automatic logic wfid_in_range(input logic [WFID_W-1:0] wfid,
                                           input int               num_wf);
        return int'(wfid) < num_wf;
    endfunction

endpackage

// File: rtl/wf_state_bank.sv
// One field's worth of per-wavefront storage. It has two write ports:
// the SALU write port and the dispatcher launch port. When both hit the
// same entry, launch wins. Out-of-range ids are ignored on write and read
// back as zero.
// Optional build macro: EXEC_RAW_BYPASS_EN forwards same-cycle writes to
// the read port.
module wf_state_bank
    import wf_exec_state_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = NUM_WF_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WFID_W-1:0] wr_wfid,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              init_en,
    input  logic [WFID_W-1:0] init_wfid,
    input  logic [WIDTH-1:0]  init_data,
    input  logic [WFID_W-1:0] rd_wfid,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage update: clear everything on reset, otherwise apply the write
    // and then the launch so that launch overrides a write to the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en && wfid_in_range(wr_wfid, DEPTH)) begin
                mem[wr_wfid] <= wr_data;
            end
            if (init_en && wfid_in_range(init_wfid, DEPTH)) begin
                mem[init_wfid] <= init_data;
            end
        end
    end

    // Combinational lookup of the addressed entry, optionally forwarding
    // data being written this cycle with the same launch-over-write priority.
    always_comb begin
        rd_data = '0;
        if (wfid_in_range(rd_wfid, DEPTH)) begin
            rd_data = mem[rd_wfid];
`ifdef EXEC_RAW_BYPASS_EN
            if (wr_en && (wr_wfid == rd_wfid)) begin
                rd_data = wr_data;
            end
            if (init_en && (init_wfid == rd_wfid)) begin
                rd_data = init_data;
            end
`else
            rd_data = mem[rd_wfid];
`endif
        end
    end

endmodule

// File: rtl/wf_exec_state.sv
// Per-wavefront EXEC/VCC/M0/SCC state with a single registered read port
// (one-cycle latency), a per-field SALU write port and a dispatcher launch
// port that loads EXEC and clears the other fields.
// Optional build macro: EXEC_RAW_BYPASS_EN makes a read see data written or
// launched in the same cycle; without it the read sees the older value.
module wf_exec_state
    import wf_exec_state_pkg::*;
#(
    parameter int NUM_WF = NUM_WF_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exec_rd_en,
    input  logic [WFID_W-1:0] exec_rd_wfid,
    output logic [EXEC_W-1:0] exec_rd_exec_value,
    output logic [VCC_W-1:0]  exec_rd_vcc_value,
    output logic [M0_W-1:0]   exec_rd_m0_value,
    output logic [SCC_W-1:0]  exec_rd_scc_value,
    output logic              exec_rd_valid,
    input  logic              exec_wr_exec_en,
    input  logic              exec_wr_vcc_en,
    input  logic              exec_wr_m0_en,
    input  logic              exec_wr_scc_en,
    input  logic [EXEC_W-1:0] exec_wr_exec_value,
    input  logic [VCC_W-1:0]  exec_wr_vcc_value,
    input  logic [M0_W-1:0]   exec_wr_m0_value,
    input  logic [SCC_W-1:0]  exec_wr_scc_value,
    input  logic [WFID_W-1:0] exec_wr_wfid,
    input  logic              wave_init_en,
    input  logic [WFID_W-1:0] wave_init_wfid,
    input  logic [EXEC_W-1:0] wave_init_exec,
    output logic              rd_execz,
    output logic              rd_vccz
);

    logic [EXEC_W-1:0] bank_exec;
    logic [VCC_W-1:0]  bank_vcc;
    logic [M0_W-1:0]   bank_m0;
    logic [SCC_W-1:0]  bank_scc;

    wf_state_bank #(.WIDTH(EXEC_W), .DEPTH(NUM_WF)) u_exec_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (exec_wr_exec_en),
        .wr_wfid   (exec_wr_wfid),
        .wr_data   (exec_wr_exec_value),
        .init_en   (wave_init_en),
        .init_wfid (wave_init_wfid),
        .init_data (wave_init_exec),
        .rd_wfid   (exec_rd_wfid),
        .rd_data   (bank_exec)
    );

    wf_state_bank #(.WIDTH(VCC_W), .DEPTH(NUM_WF)) u_vcc_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (exec_wr_vcc_en),
        .wr_wfid   (exec_wr_wfid),
        .wr_data   (exec_wr_vcc_value),
        .init_en   (wave_init_en),
        .init_wfid (wave_init_wfid),
        .init_data ('0),
        .rd_wfid   (exec_rd_wfid),
        .rd_data   (bank_vcc)
    );

    wf_state_bank #(.WIDTH(M0_W), .DEPTH(NUM_WF)) u_m0_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (exec_wr_m0_en),
        .wr_wfid   (exec_wr_wfid),
        .wr_data   (exec_wr_m0_value),
        .init_en   (wave_init_en),
        .init_wfid (wave_init_wfid),
        .init_data ('0),
        .rd_wfid   (exec_rd_wfid),
        .rd_data   (bank_m0)
    );

    wf_state_bank #(.WIDTH(SCC_W), .DEPTH(NUM_WF)) u_scc_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (exec_wr_scc_en),
        .wr_wfid   (exec_wr_wfid),
        .wr_data   (exec_wr_scc_value),
        .init_en   (wave_init_en),
        .init_wfid (wave_init_wfid),
        .init_data ('0),
        .rd_wfid   (exec_rd_wfid),
        .rd_data   (bank_scc)
    );

    // Read output register: capture bank data on a request, hold it
    // otherwise, and pulse valid for exactly the cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_rd_valid      <= 1'b0;
            exec_rd_exec_value <= '0;
            exec_rd_vcc_value  <= '0;
            exec_rd_m0_value   <= '0;
            exec_rd_scc_value  <= '0;
        end else begin
            exec_rd_valid <= exec_rd_en;
            if (exec_rd_en) begin
                exec_rd_exec_value <= bank_exec;
                exec_rd_vcc_value  <= bank_vcc;
                exec_rd_m0_value   <= bank_m0;
                exec_rd_scc_value  <= bank_scc;
            end
        end
    end

    // Zero flags derived from the registered read data.
    always_comb begin
        rd_execz = (exec_rd_exec_value == '0);
        rd_vccz  = (exec_rd_vcc_value == '0);
    end

endmodule

// File: tb/tb_wf_exec_state.sv
// Testbench for wf_exec_state: a directed vector table followed by random
// traffic checked against a behavioural model of the wavefront state.
// Honours EXEC_RAW_BYPASS_EN in the same way as the design.
module tb_wf_exec_state;

    localparam int NUM_WF = 40;

    typedef struct {
        logic        rst;
        logic        rd_en;
        logic [5:0]  rd_wfid;
        logic        wr_exec_en;
        logic        wr_vcc_en;
        logic        wr_m0_en;
        logic        wr_scc_en;
        logic [63:0] wr_exec;
        logic [63:0] wr_vcc;
        logic [31:0] wr_m0;
        logic        wr_scc;
        logic [5:0]  wr_wfid;
        logic        init_en;
        logic [5:0]  init_wfid;
        logic [63:0] init_exec;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [63:0] exec;
        logic [63:0] vcc;
        logic [31:0] m0;
        logic        scc;
    } resp_t;

    typedef struct {
        string name;
        stim_t s;
        resp_t r;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        exec_rd_en;
    logic [5:0]  exec_rd_wfid;
    logic [63:0] exec_rd_exec_value;
    logic [63:0] exec_rd_vcc_value;
    logic [31:0] exec_rd_m0_value;
    logic [0:0]  exec_rd_scc_value;
    logic        exec_rd_valid;
    logic        exec_wr_exec_en;
    logic        exec_wr_vcc_en;
    logic        exec_wr_m0_en;
    logic        exec_wr_scc_en;
    logic [63:0] exec_wr_exec_value;
    logic [63:0] exec_wr_vcc_value;
    logic [31:0] exec_wr_m0_value;
    logic [0:0]  exec_wr_scc_value;
    logic [5:0]  exec_wr_wfid;
    logic        wave_init_en;
    logic [5:0]  wave_init_wfid;
    logic [63:0] wave_init_exec;
    logic        rd_execz;
    logic        rd_vccz;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];

    logic [63:0] m_exec [NUM_WF];
    logic [63:0] m_vcc  [NUM_WF];
    logic [31:0] m_m0   [NUM_WF];
    logic        m_scc  [NUM_WF];

    wf_exec_state #(.NUM_WF(NUM_WF)) dut (
        .clk                (clk),
        .rst                (rst),
        .exec_rd_en         (exec_rd_en),
        .exec_rd_wfid       (exec_rd_wfid),
        .exec_rd_exec_value (exec_rd_exec_value),
        .exec_rd_vcc_value  (exec_rd_vcc_value),
        .exec_rd_m0_value   (exec_rd_m0_value),
        .exec_rd_scc_value  (exec_rd_scc_value),
        .exec_rd_valid      (exec_rd_valid),
        .exec_wr_exec_en    (exec_wr_exec_en),
        .exec_wr_vcc_en     (exec_wr_vcc_en),
        .exec_wr_m0_en      (exec_wr_m0_en),
        .exec_wr_scc_en     (exec_wr_scc_en),
        .exec_wr_exec_value (exec_wr_exec_value),
        .exec_wr_vcc_value  (exec_wr_vcc_value),
        .exec_wr_m0_value   (exec_wr_m0_value),
        .exec_wr_scc_value  (exec_wr_scc_value),
        .exec_wr_wfid       (exec_wr_wfid),
        .wave_init_en       (wave_init_en),
        .wave_init_wfid     (wave_init_wfid),
        .wave_init_exec     (wave_init_exec),
        .rd_execz           (rd_execz),
        .rd_vccz            (rd_vccz)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 0; s.rd_en = 0; s.rd_wfid = 0;
        s.wr_exec_en = 0; s.wr_vcc_en = 0; s.wr_m0_en = 0; s.wr_scc_en = 0;
        s.wr_exec = 0; s.wr_vcc = 0; s.wr_m0 = 0; s.wr_scc = 0; s.wr_wfid = 0;
        s.init_en = 0; s.init_wfid = 0; s.init_exec = 0;
        return s;
    endfunction

    function automatic resp_t mkResp(input logic v, input logic [63:0] e,
                                     input logic [63:0] c, input logic [31:0] m,
                                     input logic sc);
        resp_t r;
        r.valid = v; r.exec = e; r.vcc = c; r.m0 = m; r.scc = sc;
        return r;
    endfunction

    // Append a table row; a hold row expects valid=0 and the previous data.
    task automatic addRow(input string name, input stim_t s, input bit hold, input resp_t r);
        vec_t v;
        v.name = name;
        v.s    = s;
        if (hold) begin
            v.r = vecs[vecs.size()-1].r;
            v.r.valid = 1'b0;
        end else begin
            v.r = r;
        end
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then advance to just after the clock edge.
    task automatic applyStimulus(input stim_t s);
        rst                = s.rst;
        exec_rd_en         = s.rd_en;
        exec_rd_wfid       = s.rd_wfid;
        exec_wr_exec_en    = s.wr_exec_en;
        exec_wr_vcc_en     = s.wr_vcc_en;
        exec_wr_m0_en      = s.wr_m0_en;
        exec_wr_scc_en     = s.wr_scc_en;
        exec_wr_exec_value = s.wr_exec;
        exec_wr_vcc_value  = s.wr_vcc;
        exec_wr_m0_value   = s.wr_m0;
        exec_wr_scc_value  = s.wr_scc;
        exec_wr_wfid       = s.wr_wfid;
        wave_init_en       = s.init_en;
        wave_init_wfid     = s.init_wfid;
        wave_init_exec     = s.init_exec;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input resp_t e);
        cmp(name, "valid", 64'(exec_rd_valid),      64'(e.valid));
        cmp(name, "exec",  exec_rd_exec_value,      e.exec);
        cmp(name, "vcc",   exec_rd_vcc_value,       e.vcc);
        cmp(name, "m0",    64'(exec_rd_m0_value),   64'(e.m0));
        cmp(name, "scc",   64'(exec_rd_scc_value),  64'(e.scc));
        cmp(name, "execz", 64'(rd_execz),           64'(e.exec == 64'd0));
        cmp(name, "vccz",  64'(rd_vccz),            64'(e.vcc == 64'd0));
    endtask

    function automatic resp_t readModel(input logic [5:0] wfid);
        resp_t r;
        r = mkResp(1'b1, 64'd0, 64'd0, 32'd0, 1'b0);
        if (int'(wfid) < NUM_WF) begin
            r.exec = m_exec[wfid];
            r.vcc  = m_vcc[wfid];
            r.m0   = m_m0[wfid];
            r.scc  = m_scc[wfid];
        end
        return r;
    endfunction

    // Reference: a bypassing read observes the state after this cycle's
    // updates, a plain read observes the state before them.
    task automatic modelStep(input stim_t s, inout resp_t r);
        resp_t seen;
        if (s.rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                m_exec[i] = 0; m_vcc[i] = 0; m_m0[i] = 0; m_scc[i] = 0;
            end
            r = mkResp(1'b0, 64'd0, 64'd0, 32'd0, 1'b0);
            return;
        end
        seen = readModel(s.rd_wfid);
        if (int'(s.wr_wfid) < NUM_WF) begin
            if (s.wr_exec_en) m_exec[s.wr_wfid] = s.wr_exec;
            if (s.wr_vcc_en)  m_vcc[s.wr_wfid]  = s.wr_vcc;
            if (s.wr_m0_en)   m_m0[s.wr_wfid]   = s.wr_m0;
            if (s.wr_scc_en)  m_scc[s.wr_wfid]  = s.wr_scc;
        end
        if (s.init_en && int'(s.init_wfid) < NUM_WF) begin
            m_exec[s.init_wfid] = s.init_exec;
            m_vcc[s.init_wfid]  = 0;
            m_m0[s.init_wfid]   = 0;
            m_scc[s.init_wfid]  = 0;
        end
`ifdef EXEC_RAW_BYPASS_EN
        seen = readModel(s.rd_wfid);
`endif
        r.valid = s.rd_en;
        if (s.rd_en) begin
            r.exec = seen.exec; r.vcc = seen.vcc; r.m0 = seen.m0; r.scc = seen.scc;
        end
    endtask

    function automatic logic [5:0] randWfid();
        if ($urandom_range(0, 4) == 0) return 6'($urandom_range(40, 63));
        return 6'($urandom_range(0, 7));
    endfunction

    function automatic logic [63:0] randWord();
        if ($urandom_range(0, 3) == 0) return 64'd0;
        return {$urandom, $urandom};
    endfunction

    initial begin
        stim_t s;
        resp_t z;
        resp_t model_r;
        logic [63:0] raw_vcc;

        z = mkResp(1'b0, 64'd0, 64'd0, 32'd0, 1'b0);
`ifdef EXEC_RAW_BYPASS_EN
        raw_vcc = 64'd0;
`else
        raw_vcc = 64'h2222222211111111;
`endif

        s = idleStim(); s.rst = 1;
        addRow("reset0", s, 0, z);
        addRow("reset1", s, 0, z);
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 2;
        addRow("rd_after_reset", s, 0, mkResp(1, 64'd0, 64'd0, 32'd0, 0));
        s = idleStim();
        addRow("idle_hold", s, 1, z);
        s = idleStim(); s.init_en = 1; s.init_wfid = 2; s.init_exec = 64'h8888888844444444;
        addRow("init2", s, 1, z);
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 2;
        addRow("rd_init2", s, 0, mkResp(1, 64'h8888888844444444, 64'd0, 32'd0, 0));
        s = idleStim(); s.wr_wfid = 2; s.wr_vcc_en = 1; s.wr_vcc = 64'h2222222211111111;
        s.wr_scc_en = 1; s.wr_scc = 1; s.wr_exec = 64'hDEADDEADDEADDEAD; s.wr_m0 = 32'hDEAD;
        addRow("wr_vcc_scc2", s, 1, z);
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 2;
        addRow("rd_vcc_scc2", s, 0, mkResp(1, 64'h8888888844444444, 64'h2222222211111111, 32'd0, 1));
        s = idleStim(); s.wr_wfid = 2; s.wr_vcc_en = 1; s.wr_vcc = 64'd0; s.rd_en = 1; s.rd_wfid = 2;
        addRow("raw_vcc2", s, 0, mkResp(1, 64'h8888888844444444, raw_vcc, 32'd0, 1));
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 2;
        addRow("rd_after_raw", s, 0, mkResp(1, 64'h8888888844444444, 64'd0, 32'd0, 1));
        s = idleStim(); s.init_en = 1; s.init_wfid = 5; s.init_exec = 64'h0123456789ABCDEF;
        s.wr_wfid = 5; s.wr_exec_en = 1; s.wr_exec = 64'hFFFF; s.wr_vcc_en = 1; s.wr_vcc = 64'h5555;
        s.wr_m0_en = 1; s.wr_m0 = 32'h77; s.wr_scc_en = 1; s.wr_scc = 1;
        addRow("init_vs_wr5", s, 1, z);
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 5;
        addRow("rd5_init_wins", s, 0, mkResp(1, 64'h0123456789ABCDEF, 64'd0, 32'd0, 0));
        s = idleStim(); s.wr_wfid = 45; s.wr_exec_en = 1; s.wr_exec = '1; s.wr_vcc_en = 1; s.wr_vcc = '1;
        s.wr_m0_en = 1; s.wr_m0 = '1; s.wr_scc_en = 1; s.wr_scc = 1;
        s.init_en = 1; s.init_wfid = 47; s.init_exec = 64'h1;
        addRow("wr45", s, 1, z);
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 45;
        addRow("rd45_zero", s, 0, mkResp(1, 64'd0, 64'd0, 32'd0, 0));
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 5;
        addRow("rd5_untouched", s, 0, mkResp(1, 64'h0123456789ABCDEF, 64'd0, 32'd0, 0));
        s = idleStim(); s.init_en = 1; s.init_wfid = 7; s.init_exec = 64'hA5A5A5A5A5A5A5A5;
        s.wr_wfid = 6; s.wr_m0_en = 1; s.wr_m0 = 32'h12345678;
        addRow("init7_wr6", s, 1, z);
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 6;
        addRow("rd6", s, 0, mkResp(1, 64'd0, 64'd0, 32'h12345678, 0));
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 7;
        addRow("rd7", s, 0, mkResp(1, 64'hA5A5A5A5A5A5A5A5, 64'd0, 32'd0, 0));
        s = idleStim(); s.rst = 1; s.rd_en = 1; s.rd_wfid = 7; s.init_en = 1; s.init_wfid = 7;
        s.init_exec = 64'hFF; s.wr_wfid = 7; s.wr_exec_en = 1; s.wr_exec = 64'hF0;
        addRow("reset_wins", s, 0, z);
        s = idleStim();
        addRow("no_valid_after_reset", s, 0, z);
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 7;
        addRow("rd7_cleared", s, 0, mkResp(1, 64'd0, 64'd0, 32'd0, 0));
        s = idleStim(); s.rd_en = 1; s.rd_wfid = 2;
        addRow("rd2_cleared", s, 0, mkResp(1, 64'd0, 64'd0, 32'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s);
            checkOutput(vecs[i].name, vecs[i].r);
        end

        model_r = z;
        s = idleStim(); s.rst = 1;
        modelStep(s, model_r);
        applyStimulus(s);
        checkOutput("rand_reset", model_r);

        for (int n = 0; n < 400; n++) begin
            s = idleStim();
            s.rst        = ($urandom_range(0, 59) == 0);
            s.rd_en      = 1'($urandom_range(0, 1));
            s.rd_wfid    = randWfid();
            s.wr_exec_en = 1'($urandom_range(0, 1));
            s.wr_vcc_en  = 1'($urandom_range(0, 1));
            s.wr_m0_en   = 1'($urandom_range(0, 1));
            s.wr_scc_en  = 1'($urandom_range(0, 1));
            s.wr_exec    = randWord();
            s.wr_vcc     = randWord();
            s.wr_m0      = $urandom;
            s.wr_scc     = 1'($urandom_range(0, 1));
            s.wr_wfid    = randWfid();
            s.init_en    = ($urandom_range(0, 3) == 0);
            s.init_wfid  = randWfid();
            s.init_exec  = randWord();
            modelStep(s, model_r);
            applyStimulus(s);
            checkOutput("rand", model_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
